// File: rtl/pwm_note_sequencer_ram.sv
// ---------------------------------------------------------------------------
// pwm_note_sequencer_ram
//
// Plays a song stored in an internal RAM of DEPTH entries. Each entry is
// {note code, length code}; a note lasts (len+1) tempo units of UNIT_TICKS
// clock cycles. The last GAP_TICKS cycles of every note are gated off so
// repeated notes are audibly separated. Playback supports start, stop and
// looping back to entry 0 after the final entry.
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_wr_en           song RAM write strobe (accepted in every state)
//   i_wr_addr         RAM write address
//   i_wr_note         note code to write (0 = rest)
//   i_wr_len          length code to write
//   i_last_addr       index of the final entry, captured on an accepted start
//   i_start           start pulse (only honoured in IDLE, and only without stop)
//   i_stop            stop pulse (returns to IDLE from any other state)
//   i_loop            loop enable, sampled when the final entry completes
//   o_note            current note code, 0 while the gate is low
//   o_note_valid      one-cycle pulse while a new entry is being latched
//   o_gate            voice enable
//   o_busy            high in every state except IDLE
//   o_index           entry currently fetched or playing
//   o_done            one-cycle pulse after a non-looping song ends
// ---------------------------------------------------------------------------
module pwm_note_sequencer_ram #(
    parameter int DEPTH      = 32,
    parameter int NOTE_W     = 6,
    parameter int LEN_W      = 5,
    parameter int UNIT_TICKS = 1562500,
    parameter int GAP_TICKS  = 250000,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [NOTE_W-1:0] i_wr_note,
    input  logic [LEN_W-1:0]  i_wr_len,
    input  logic [AW-1:0]     i_last_addr,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    output logic [NOTE_W-1:0] o_note,
    output logic              o_note_valid,
    output logic              o_gate,
    output logic              o_busy,
    output logic [AW-1:0]     o_index,
    output logic              o_done
);

    localparam int ENTRY_W = NOTE_W + LEN_W;
    localparam int CNT_W   = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;

    // Terminal count of a unit, and the count at which the trailing gap
    // begins inside the final unit of a note.
    localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(UNIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(UNIT_TICKS - GAP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        PLAY,
        GAP
    } state_t;

    state_t state;
    state_t next_state;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rd_data;

    logic [NOTE_W-1:0] note;
    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  unit_cnt;
    logic [LEN_W-1:0]  unit_idx;
    logic [AW-1:0]     index;
    logic [AW-1:0]     last;
    logic              done;

    logic start_ok;
    logic last_unit;
    logic note_end;
    logic gap_start;
    logic song_end;

    assign start_ok  = i_start && !i_stop;
    assign last_unit = (unit_idx == len);
    assign note_end  = last_unit && (unit_cnt == CNT_WRAP);
    assign gap_start = last_unit && (unit_cnt == CNT_GAP);
    assign song_end  = (index == last) && !i_loop;

    // Song RAM: one write port, one synchronous read port addressed by the
    // current index. The non-blocking read naturally returns the old word
    // when the same address is written in the same cycle. The contents are
    // deliberately left out of reset so a song survives a reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= {i_wr_note, i_wr_len};
        end
        rd_data <= mem[index];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and the state-decoded outputs. End-of-note is tested
    // before the gap entry so that a zero-length gap goes straight to the
    // next entry. Stop overrides every transition out of a busy state.
    always_comb begin
        next_state   = state;
        o_gate       = 1'b0;
        o_note       = '0;
        o_note_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                next_state = LATCH;
            end
            LATCH: begin
                o_note_valid = 1'b1;
                next_state   = PLAY;
            end
            PLAY: begin
                o_gate = (note != '0);
                o_note = note;
                if (note_end) begin
                    next_state = song_end ? IDLE : FETCH;
                end else if (gap_start) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (note_end) begin
                    next_state = song_end ? IDLE : FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if ((state != IDLE) && i_stop) begin
            next_state = IDLE;
        end
    end

    // Datapath registers: song bounds, the latched entry, the unit
    // counter pair that times the note without a multiplier, and the
    // registered done pulse that appears in the first IDLE cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            index    <= '0;
            last     <= '0;
            note     <= '0;
            len      <= '0;
            unit_cnt <= '0;
            unit_idx <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        last  <= i_last_addr;
                        index <= '0;
                    end
                end
                LATCH: begin
                    note     <= rd_data[ENTRY_W-1:LEN_W];
                    len      <= rd_data[LEN_W-1:0];
                    unit_cnt <= '0;
                    unit_idx <= '0;
                end
                PLAY, GAP: begin
                    if (unit_cnt == CNT_WRAP) begin
                        unit_cnt <= '0;
                        unit_idx <= unit_idx + LEN_W'(1);
                    end else begin
                        unit_cnt <= unit_cnt + CNT_W'(1);
                    end
                    if (note_end && !i_stop) begin
                        if (index != last) begin
                            index <= index + AW'(1);
                        end else if (i_loop) begin
                            index <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_index = index;
    assign o_done  = done;

endmodule

// File: tb/tb_pwm_note_sequencer_ram.sv
// ---------------------------------------------------------------------------
// tb_pwm_note_sequencer_ram
//
// Scoreboard bench for pwm_note_sequencer_ram with a short tempo unit.
// Stimulus writes songs into the RAM model and the DUT, then pushes the
// expected sequence of played entries and done events. A monitor watches
// o_note_valid/o_gate/o_busy/o_done, measures each entry, and compares it
// with the next queued expectation.
// ---------------------------------------------------------------------------
module tb_pwm_note_sequencer_ram;

    localparam int DEPTH  = 8;
    localparam int NOTE_W = 6;
    localparam int LEN_W  = 5;
    localparam int UNIT   = 4;
    localparam int GAP    = 1;
    localparam int AW     = 3;

    localparam int KIND_ENTRY = 0;
    localparam int KIND_DONE  = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [NOTE_W-1:0] wr_note = '0;
    logic [LEN_W-1:0]  wr_len = '0;
    logic [AW-1:0]     last_addr = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [NOTE_W-1:0] note;
    logic              note_valid;
    logic              gate;
    logic              busy;
    logic [AW-1:0]     index;
    logic              done;

    pwm_note_sequencer_ram #(
        .DEPTH(DEPTH),
        .NOTE_W(NOTE_W),
        .LEN_W(LEN_W),
        .UNIT_TICKS(UNIT),
        .GAP_TICKS(GAP)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_wr_en(wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_note(wr_note),
        .i_wr_len(wr_len),
        .i_last_addr(last_addr),
        .i_start(start),
        .i_stop(stop),
        .i_loop(loop_en),
        .o_note(note),
        .o_note_valid(note_valid),
        .o_gate(gate),
        .o_busy(busy),
        .o_index(index),
        .o_done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int idx;
        int note;
        int gate_high;
        int total;
        bit trunc;
    } rec_t;

    rec_t sb[$];
    int   mem_note [DEPTH];
    int   mem_len  [DEPTH];
    int   checks = 0;
    int   failures = 0;
    int   valid_count = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: an entry lasts (len+1) units after its latch cycle,
    // plus one fetch cycle when another entry follows. Gate is high for all
    // but the trailing gap, or never for a rest.
    task automatic pushEntry(input int i, input bit ends_song);
        rec_t r;
        r.kind      = KIND_ENTRY;
        r.idx       = i;
        r.note      = mem_note[i];
        r.gate_high = (mem_note[i] != 0) ? (mem_len[i] + 1) * UNIT - GAP : 0;
        r.total     = (mem_len[i] + 1) * UNIT + (ends_song ? 1 : 2);
        r.trunc     = 1'b0;
        sb.push_back(r);
    endtask

    task automatic pushTrunc(input int i);
        rec_t r;
        r.kind      = KIND_ENTRY;
        r.idx       = i;
        r.note      = mem_note[i];
        r.gate_high = 0;
        r.total     = 0;
        r.trunc     = 1'b1;
        sb.push_back(r);
    endtask

    task automatic pushSong(input int last, input int passes, input bit with_done);
        rec_t r;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i <= last; i++) begin
                pushEntry(i, with_done && (p == passes - 1) && (i == last));
            end
        end
        if (with_done) begin
            r.kind = KIND_DONE;
            r.idx = 0; r.note = 0; r.gate_high = 0; r.total = 0; r.trunc = 1'b0;
            sb.push_back(r);
        end
    endtask

    // Monitor state for the entry currently being measured.
    bit   open_e = 1'b0;
    int   cur_idx, cnt, gh, note_seen;
    bit   note_bad;
    rec_t mon_r;

    task automatic closeEntry();
        if (sb.size() == 0) begin
            checkOutput("unexpected_entry", 1, 0);
        end else begin
            mon_r = sb.pop_front();
            checkOutput("event_kind_entry", KIND_ENTRY, mon_r.kind);
            checkOutput("entry_index", cur_idx, mon_r.idx);
            if (!mon_r.trunc) begin
                checkOutput("gate_high_cycles", gh, mon_r.gate_high);
                checkOutput("entry_cycles", cnt, mon_r.total);
            end
            if (gh > 0) begin
                checkOutput("note_code", note_seen, mon_r.note);
            end
            checkOutput("note_consistent", int'(note_bad), 0);
        end
        open_e = 1'b0;
    endtask

    always @(negedge clk) begin
        if (open_e && (!rst_n || note_valid || !busy)) begin
            closeEntry();
        end
        if (rst_n && note_valid) begin
            open_e    = 1'b1;
            cur_idx   = int'(index);
            cnt       = 0;
            gh        = 0;
            note_seen = 0;
            note_bad  = 1'b0;
            valid_count++;
        end
        if (open_e) begin
            cnt++;
            if (gate) begin
                gh++;
                if (gh == 1) begin
                    note_seen = int'(note);
                end else if (int'(note) != note_seen) begin
                    note_bad = 1'b1;
                end
            end else if (note != '0) begin
                note_bad = 1'b1;
            end
        end
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                mon_r = sb.pop_front();
                checkOutput("event_kind_done", KIND_DONE, mon_r.kind);
                checkOutput("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic writeEntry(input int a, input int n, input int l);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_note = NOTE_W'(n);
        wr_len  = LEN_W'(l);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        mem_note[a] = n;
        mem_len[a]  = l;
    endtask

    task automatic applyStimulus(input bit s_start, input bit s_stop);
        start = s_start;
        stop  = s_stop;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic waitValids(input int target, input int budget);
        int n = 0;
        while (valid_count < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("wait_valid_reached", int'(valid_count >= target), 1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("wait_idle_reached", int'(busy), 0);
    endtask

    task automatic drainCheck();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic randomSong(input int last, input int max_len);
        for (int i = 0; i <= last; i++) begin
            writeEntry(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63)),
                       int'($urandom_range(0, max_len)));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        int last;

        // Asynchronous reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_gate", int'(gate), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_note", int'(note), 0);
        checkOutput("reset_valid", int'(note_valid), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_index", int'(index), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Reference song, played once to completion.
        writeEntry(0, 5, 0);
        writeEntry(1, 9, 1);
        writeEntry(2, 0, 0);
        last_addr = 3'd2;
        loop_en   = 1'b0;
        pushSong(2, 1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitIdle(200);
        drainCheck();

        // Same song looping three times, then stopped as the fourth pass latches.
        loop_en = 1'b1;
        base = valid_count;
        pushSong(2, 3, 1'b0);
        pushTrunc(0);
        applyStimulus(1'b1, 1'b0);
        waitValids(base + 10, 500);
        applyStimulus(1'b0, 1'b1);
        checkOutput("loop_stop_busy", int'(busy), 0);
        loop_en = 1'b0;
        drainCheck();

        // Stop in the second PLAY cycle of note 9, then restart from entry 0.
        base = valid_count;
        pushEntry(0, 1'b0);
        pushTrunc(1);
        applyStimulus(1'b1, 1'b0);
        waitValids(base + 2, 100);
        repeat (2) @(negedge clk);
        #1;
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop_gate", int'(gate), 0);
        checkOutput("stop_note", int'(note), 0);
        checkOutput("stop_busy", int'(busy), 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("stop_no_done", int'(done), 0);
        end
        drainCheck();
        pushSong(2, 1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitIdle(200);
        drainCheck();

        // Start and stop together in IDLE must leave the block idle.
        base = valid_count;
        applyStimulus(1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("start_stop_idle", int'(busy), 0);
        end
        checkOutput("start_stop_no_entry", valid_count, base);

        // Random non-looping songs with a stray start pulse while playing.
        for (int t = 0; t < 6; t++) begin
            last = int'($urandom_range(0, DEPTH - 1));
            randomSong(last, 3);
            last_addr = AW'(last);
            pushSong(last, 1, 1'b1);
            applyStimulus(1'b1, 1'b0);
            n = int'($urandom_range(3, 20));
            repeat (n) @(negedge clk);
            #1;
            if (busy) begin
                applyStimulus(1'b1, 1'b0);
            end
            waitIdle(1000);
            drainCheck();
        end

        // Full-depth loop with a long final entry; entry 0 is rewritten while
        // entry 7 plays, so the second pass must use the new contents.
        randomSong(6, 1);
        writeEntry(7, int'($urandom_range(1, 63)), 31);
        last_addr = 3'd7;
        loop_en   = 1'b1;
        base = valid_count;
        pushSong(7, 1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitValids(base + 8, 400);
        writeEntry(0, int'($urandom_range(1, 63)), int'($urandom_range(0, 3)));
        pushEntry(0, 1'b0);
        pushEntry(1, 1'b0);
        pushTrunc(2);
        waitValids(base + 11, 1000);
        applyStimulus(1'b0, 1'b1);
        loop_en = 1'b0;
        drainCheck();

        // Asynchronous reset between clock edges while the gate is high.
        writeEntry(0, 12, 1);
        last_addr = 3'd0;
        base = valid_count;
        pushTrunc(0);
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (!gate && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("gate_seen_before_reset", int'(gate), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_gate", int'(gate), 0);
        checkOutput("async_reset_busy", int'(busy), 0);
        checkOutput("async_reset_note", int'(note), 0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("idle_after_reset", int'(busy), 0);
        checkOutput("no_entry_after_reset", valid_count, base + 1);
        drainCheck();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
